// File: rtl/tlb_assoc.sv
// Fully-associative Sv39 TLB: combinational lookup, tree-PLRU replacement, filtered invalidate.
// Define TLB_SUPERPAGE_EN to store the leaf level and translate 2M/1G superpages.
module tlb_assoc #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned ASID_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [38:0]       va,
    input  logic [ASID_W-1:0] asid,
    input  logic              rreq,
    output logic              hit,
    output logic [63:0]       pa,
    output logic [7:0]        pte_flags,
    input  logic              fill_req,
    input  logic [26:0]       fill_vpn,
    input  logic [63:0]       fill_pte,
    input  logic [1:0]        fill_level,
    input  logic              inv_req,
    input  logic              inv_use_va,
    input  logic              inv_use_asid,
    input  logic [38:0]       inv_va,
    input  logic [ASID_W-1:0] inv_asid
);
    localparam int unsigned IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned NODES  = ENTRIES - 1;
    localparam int unsigned VPN_W  = 27;
    localparam int unsigned DATA_W = 54;
    localparam int unsigned PPN_W  = 44;
    localparam int unsigned G_BIT  = 5;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [NODES-1:0]   plru_q, plru_d;
    logic [ASID_W-1:0]  asid_q [ENTRIES];
    logic [ASID_W-1:0]  asid_d [ENTRIES];
    logic [VPN_W-1:0]   vpn_q  [ENTRIES];
    logic [VPN_W-1:0]   vpn_d  [ENTRIES];
    logic [DATA_W-1:0]  data_q [ENTRIES];
    logic [DATA_W-1:0]  data_d [ENTRIES];
`ifdef TLB_SUPERPAGE_EN
    logic [1:0]         level_q [ENTRIES];
    logic [1:0]         level_d [ENTRIES];
`endif

    logic [VPN_W-1:0]   mask [ENTRIES];
    logic [ENTRIES-1:0] lu_match, fl_match, inv_sel;
    logic               hit_any, fl_hit, free_any;
    logic [IDX_W-1:0]   hit_idx, fl_hit_idx, free_idx, victim_idx, fill_idx;
    logic [PPN_W-1:0]   ppn;

    // Walk the tree from the root; a 0 bit points the victim at the left child.
    function automatic logic [IDX_W-1:0] plru_victim(input logic [NODES-1:0] t);
        int unsigned node;
        node = 0;
        for (int unsigned d = 0; d < IDX_W; d++) begin
            node = 2 * node + 1 + (t[IDX_W'(node)] ? 32'd1 : 32'd0);
        end
        return IDX_W'(node - NODES);
    endfunction

    // Point every node on the path to entry e away from it.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t,
                                                    input logic [IDX_W-1:0] e);
        logic [NODES-1:0] r;
        logic [IDX_W-1:0] path;
        logic             dir;
        int unsigned      node;
        r    = t;
        path = e;
        node = 0;
        for (int unsigned d = 0; d < IDX_W; d++) begin
            dir             = path[IDX_W-1];
            path            = path << 1;
            r[IDX_W'(node)] = ~dir;
            node            = 2 * node + 1 + (dir ? 32'd1 : 32'd0);
        end
        return r;
    endfunction

    // Per-entry VPN compare mask; superpages ignore the low VPN fields.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
`ifdef TLB_SUPERPAGE_EN
            case (level_q[i])
                2'd1:    mask[i] = {18'h3ffff, 9'h000};
                2'd2:    mask[i] = {9'h1ff, 18'h00000};
                default: mask[i] = '1;
            endcase
`else
            mask[i] = '1;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            lu_match[i] = valid_q[i]
                        && (data_q[i][G_BIT] || (asid_q[i] == asid))
                        && (((va[38:12] ^ vpn_q[i]) & mask[i]) == '0);
            fl_match[i] = valid_q[i]
                        && (data_q[i][G_BIT] || (asid_q[i] == asid))
                        && (((fill_vpn ^ vpn_q[i]) & mask[i]) == '0);
            inv_sel[i]  = (!inv_use_va || (((inv_va[38:12] ^ vpn_q[i]) & mask[i]) == '0))
                        && (!inv_use_asid || (!data_q[i][G_BIT] && (asid_q[i] == inv_asid)));
        end
    end

    // Lowest-index priority encoders for lookup hit, fill overwrite and free slot.
    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = '0;
        fl_hit     = 1'b0;
        fl_hit_idx = '0;
        free_any   = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lu_match[i] && !hit_any) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (fl_match[i] && !fl_hit) begin
                fl_hit     = 1'b1;
                fl_hit_idx = IDX_W'(i);
            end
            if (!valid_q[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        victim_idx = plru_victim(plru_q);
        if (fl_hit) begin
            fill_idx = fl_hit_idx;
        end else if (free_any) begin
            fill_idx = free_idx;
        end else begin
            fill_idx = victim_idx;
        end
    end

    // Translation output; superpage PPN fields are taken from the VA.
    always_comb begin
        hit       = 1'b0;
        pa        = '0;
        pte_flags = '0;
        ppn       = '0;
        if (rreq && hit_any) begin
            hit = 1'b1;
            ppn = data_q[hit_idx][53:10];
`ifdef TLB_SUPERPAGE_EN
            case (level_q[hit_idx])
                2'd1:    ppn[8:0]  = va[20:12];
                2'd2:    ppn[17:0] = va[29:12];
                default: ;
            endcase
`endif
            pa        = {8'b0, ppn, va[11:0]};
            pte_flags = data_q[hit_idx][7:0];
        end
    end

    // Invalidate beats fill; a fill's MRU update overrides the lookup's.
    always_comb begin
        valid_d = valid_q;
        plru_d  = plru_q;
        asid_d  = asid_q;
        vpn_d   = vpn_q;
        data_d  = data_q;
`ifdef TLB_SUPERPAGE_EN
        level_d = level_q;
`endif
        if (hit) begin
            plru_d = plru_touch(plru_q, hit_idx);
        end
        if (inv_req) begin
            valid_d = valid_q & ~inv_sel;
        end else if (fill_req) begin
            valid_d[fill_idx] = 1'b1;
            asid_d[fill_idx]  = asid;
            vpn_d[fill_idx]   = fill_vpn;
            data_d[fill_idx]  = fill_pte[DATA_W-1:0];
`ifdef TLB_SUPERPAGE_EN
            level_d[fill_idx] = fill_level;
`endif
            plru_d = plru_touch(plru_q, fill_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else begin
            valid_q <= valid_d;
            plru_q  <= plru_d;
        end
    end

    // Tag and data payload need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        asid_q  <= asid_d;
        vpn_q   <= vpn_d;
        data_q  <= data_d;
`ifdef TLB_SUPERPAGE_EN
        level_q <= level_d;
`endif
    end

    logic [ENTRIES-1:0] unused_rsw;
    logic               unused_ok;
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            unused_rsw[i] = ^data_q[i][9:8];
        end
    end
`ifdef TLB_SUPERPAGE_EN
    assign unused_ok = ^{fill_pte[63:54], inv_va[11:0], unused_rsw};
`else
    assign unused_ok = ^{fill_pte[63:54], inv_va[11:0], unused_rsw, fill_level};
`endif

endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc: directed stimulus pushes expected lookup results,
// a negedge monitor pops and compares them.
module tb_tlb_assoc;
    localparam int unsigned ENTRIES = 4;
    localparam int unsigned ASID_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [38:0]       va;
    logic [ASID_W-1:0] asid;
    logic              rreq;
    logic              hit;
    logic [63:0]       pa;
    logic [7:0]        pte_flags;
    logic              fill_req;
    logic [26:0]       fill_vpn;
    logic [63:0]       fill_pte;
    logic [1:0]        fill_level;
    logic              inv_req;
    logic              inv_use_va;
    logic              inv_use_asid;
    logic [38:0]       inv_va;
    logic [ASID_W-1:0] inv_asid;

    tlb_assoc #(.ENTRIES(ENTRIES), .ASID_W(ASID_W)) dut (
        .clk(clk), .rst(rst), .va(va), .asid(asid), .rreq(rreq),
        .hit(hit), .pa(pa), .pte_flags(pte_flags),
        .fill_req(fill_req), .fill_vpn(fill_vpn), .fill_pte(fill_pte), .fill_level(fill_level),
        .inv_req(inv_req), .inv_use_va(inv_use_va), .inv_use_asid(inv_use_asid),
        .inv_va(inv_va), .inv_asid(inv_asid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic [63:0] pa;
        logic [7:0]  flags;
    } exp_t;

    exp_t  exp_q [$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  mon_en = 1'b0;

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] f);
        return {10'b0, ppn, 2'b00, f};
    endfunction

    task automatic clear_reqs();
        rreq         = 1'b0;
        fill_req     = 1'b0;
        inv_req      = 1'b0;
        inv_use_va   = 1'b0;
        inv_use_asid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_reqs();
    endtask

    task automatic set_lookup(input logic [38:0] a, input logic [15:0] id, input logic eh,
                              input logic [63:0] ep, input logic [7:0] ef, input string nm);
        exp_t e;
        e.hit   = eh;
        e.pa    = ep;
        e.flags = ef;
        exp_q.push_back(e);
        name_q.push_back(nm);
        rreq = 1'b1;
        va   = a;
        asid = id;
    endtask

    task automatic set_fill(input logic [26:0] vpn, input logic [15:0] id, input logic [43:0] ppn,
                            input logic [7:0] f, input logic [1:0] lvl);
        fill_req   = 1'b1;
        fill_vpn   = vpn;
        asid       = id;
        fill_pte   = mk_pte(ppn, f);
        fill_level = lvl;
    endtask

    task automatic set_inv(input logic uva, input logic uasid, input logic [38:0] iva,
                           input logic [15:0] iasid);
        inv_req      = 1'b1;
        inv_use_va   = uva;
        inv_use_asid = uasid;
        inv_va       = iva;
        inv_asid     = iasid;
    endtask

    task automatic lookup(input logic [38:0] a, input logic [15:0] id, input logic eh,
                          input logic [63:0] ep, input logic [7:0] ef, input string nm);
        set_lookup(a, id, eh, ep, ef, nm);
        tick();
    endtask

    task automatic fill(input logic [26:0] vpn, input logic [15:0] id, input logic [43:0] ppn,
                        input logic [7:0] f, input logic [1:0] lvl);
        set_fill(vpn, id, ppn, f, lvl);
        tick();
    endtask

    // Monitor: lookups pop the scoreboard, idle cycles must present all-zero outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rreq) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_lookup: no expected entry queued, got hit=%0b pa=%h",
                             hit, pa);
                end else begin
                    exp_t  e;
                    string nm;
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (hit !== e.hit || pa !== e.pa || pte_flags !== e.flags) begin
                        errors++;
                        $display("FAIL %s: got hit=%0b pa=%h flags=%h, expected hit=%0b pa=%h flags=%h",
                                 nm, hit, pa, pte_flags, e.hit, e.pa, e.flags);
                    end
                end
            end else begin
                checks++;
                if (hit !== 1'b0 || pa !== 64'h0 || pte_flags !== 8'h0) begin
                    errors++;
                    $display("FAIL idle_zero: got hit=%0b pa=%h flags=%h, expected all zero",
                             hit, pa, pte_flags);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        clear_reqs();
        va         = '0;
        asid       = '0;
        fill_vpn   = '0;
        fill_pte   = '0;
        fill_level = '0;
        inv_va     = '0;
        inv_asid   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        lookup(39'h1234, 16'd5, 1'b0, 64'h0, 8'h00, "after_reset");

        // Basic translation and ASID filtering
        fill(27'h1, 16'd5, 44'h80000, 8'h03, 2'd0);
        lookup(39'h1234, 16'd5, 1'b1, 64'h80000234, 8'h03, "basic_hit");
        lookup(39'h1234, 16'd6, 1'b0, 64'h0, 8'h00, "asid_mismatch");

        // Lookup during a fill sees the old contents
        set_fill(27'h2, 16'd5, 44'h80002, 8'h07, 2'd0);
        set_lookup(39'h2010, 16'd5, 1'b0, 64'h0, 8'h00, "fill_same_cycle");
        tick();
        lookup(39'h2010, 16'd5, 1'b1, 64'h80002010, 8'h07, "fill_visible");

        // Fill to capacity, touch 0,2,1 so entry 3 becomes the PLRU victim
        fill(27'h3, 16'd5, 44'h80003, 8'h03, 2'd0);
        fill(27'h4, 16'd5, 44'h80004, 8'h03, 2'd0);
        lookup(39'h1000, 16'd5, 1'b1, 64'h80000000, 8'h03, "touch_e0");
        lookup(39'h3000, 16'd5, 1'b1, 64'h80003000, 8'h03, "touch_e2");
        lookup(39'h2000, 16'd5, 1'b1, 64'h80002000, 8'h07, "touch_e1");
        fill(27'h5, 16'd5, 44'h80005, 8'h03, 2'd0);
        lookup(39'h4000, 16'd5, 1'b0, 64'h0, 8'h00, "victim_evicted");
        lookup(39'h5000, 16'd5, 1'b1, 64'h80005000, 8'h03, "victim_new");
        lookup(39'h1000, 16'd5, 1'b1, 64'h80000000, 8'h03, "keep_e0");
        lookup(39'h2000, 16'd5, 1'b1, 64'h80002000, 8'h07, "keep_e1");
        lookup(39'h3000, 16'd5, 1'b1, 64'h80003000, 8'h03, "keep_e2");

        // Refill of a present vpn/asid overwrites in place
        fill(27'h2, 16'd5, 44'h90002, 8'h03, 2'd0);
        lookup(39'h2000, 16'd5, 1'b1, 64'h90002000, 8'h03, "refill_new_ppn");
        lookup(39'h1000, 16'd5, 1'b1, 64'h80000000, 8'h03, "refill_occ_e0");
        lookup(39'h3000, 16'd5, 1'b1, 64'h80003000, 8'h03, "refill_occ_e2");
        lookup(39'h5000, 16'd5, 1'b1, 64'h80005000, 8'h03, "refill_occ_e3");

        // Unfiltered invalidate, then global entries vs ASID invalidate
        set_inv(1'b0, 1'b0, 39'h0, 16'd0);
        tick();
        lookup(39'h1000, 16'd5, 1'b0, 64'h0, 8'h00, "inv_all_e0");
        lookup(39'h5000, 16'd5, 1'b0, 64'h0, 8'h00, "inv_all_e3");
        fill(27'h10, 16'd3, 44'h80010, 8'h23, 2'd0);
        fill(27'h11, 16'd3, 44'h80011, 8'h03, 2'd0);
        set_inv(1'b0, 1'b1, 39'h0, 16'd3);
        tick();
        lookup(39'h10000, 16'd9, 1'b1, 64'h80010000, 8'h23, "global_survives_asid_inv");
        lookup(39'h11000, 16'd3, 1'b0, 64'h0, 8'h00, "asid_inv_clears");
        set_inv(1'b0, 1'b0, 39'h0, 16'd0);
        tick();
        lookup(39'h10000, 16'd9, 1'b0, 64'h0, 8'h00, "inv_all_clears_global");

        // VA-filtered invalidate
        fill(27'h20, 16'd4, 44'h80020, 8'h03, 2'd0);
        fill(27'h21, 16'd4, 44'h80021, 8'h03, 2'd0);
        set_inv(1'b1, 1'b0, 39'h21abc, 16'd0);
        tick();
        lookup(39'h20000, 16'd4, 1'b1, 64'h80020000, 8'h03, "va_inv_keeps_other");
        lookup(39'h21000, 16'd4, 1'b0, 64'h0, 8'h00, "va_inv_clears");
        set_inv(1'b1, 1'b1, 39'h20000, 16'd7);
        tick();
        lookup(39'h20000, 16'd4, 1'b1, 64'h80020000, 8'h03, "va_asid_inv_no_match");

        // Lookup during an invalidate sees the old contents
        set_inv(1'b0, 1'b0, 39'h0, 16'd0);
        set_lookup(39'h20123, 16'd4, 1'b1, 64'h80020123, 8'h03, "inv_same_cycle");
        tick();
        lookup(39'h20123, 16'd4, 1'b0, 64'h0, 8'h00, "inv_applied");

        // Invalidate and fill together: fill is dropped
        set_inv(1'b0, 1'b0, 39'h0, 16'd0);
        set_fill(27'h30, 16'd4, 44'h80030, 8'h03, 2'd0);
        tick();
        lookup(39'h30000, 16'd4, 1'b0, 64'h0, 8'h00, "inv_beats_fill");

        // Two matching entries: lowest index wins
        fill(27'h50, 16'd1, 44'hA0050, 8'h03, 2'd0);
        fill(27'h50, 16'd2, 44'hB0050, 8'h23, 2'd0);
        lookup(39'h50000, 16'd1, 1'b1, 64'hA0050000, 8'h03, "lowest_index_wins");
        lookup(39'h50000, 16'd2, 1'b1, 64'hB0050000, 8'h23, "global_match");

`ifdef TLB_SUPERPAGE_EN
        fill(27'h200, 16'd1, 44'h80200, 8'h03, 2'd1);
        lookup(39'h2ABCDE, 16'd1, 1'b1, 64'h802ABCDE, 8'h03, "superpage_2m");
        fill(27'h40000, 16'd1, 44'hC0000, 8'h03, 2'd2);
        lookup(39'h5ABCDEF0, 16'd1, 1'b1, 64'hDABCDEF0, 8'h03, "superpage_1g");
`else
        fill(27'h200, 16'd1, 44'h80200, 8'h03, 2'd1);
        lookup(39'h2ABCDE, 16'd1, 1'b0, 64'h0, 8'h00, "level_ignored_miss");
        lookup(39'h200123, 16'd1, 1'b1, 64'h80200123, 8'h03, "level_ignored_4k");
`endif

        // Reset mid-operation overrides a concurrent fill
        rst = 1'b1;
        set_fill(27'h60, 16'd1, 44'h80060, 8'h03, 2'd0);
        tick();
        rst = 1'b0;
        lookup(39'h50000, 16'd1, 1'b0, 64'h0, 8'h00, "reset_clears");
        lookup(39'h60000, 16'd1, 1'b0, 64'h0, 8'h00, "reset_beats_fill");

        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
